// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the 5-stage RV32I pipeline.
//   Drives the req/ready data-memory bus and formats load/store data. It
//   flags misaligned or unsupported accesses, stalls upstream while an access
//   is outstanding, aborts on a bus timeout, and holds the MEM/WB register.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   ValidM..PCPlus4M         EX/MEM register contents
//   dmem_req/we/addr/be/wdata, dmem_ready/rdata   data-memory bus
//   StallM                   hold IF/ID/EX/MEM this cycle
//   ALU_ResultW, ReadDataW, PCPlus4W, RdW, RegWriteEnW, MemtoRegW, JALW
//                            MEM/WB register
//   MisalignW                misaligned/unsupported access retired (1 cycle)
//   BusErrW                  access aborted by timeout (1 cycle)
module memory_stage #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ValidM,
   input  logic [XLEN-1:0] ALU_ResultM,
   input  logic [XLEN-1:0] WriteDataM,
   input  logic [2:0]      Funct3M,
   input  logic            MemReadM,
   input  logic            MemWriteM,
   input  logic            MemtoRegM,
   input  logic            JALM,
   input  logic            RegWriteEnM,
   input  logic [4:0]      RdM,
   input  logic [XLEN-1:0] PCPlus4M,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            StallM,
   output logic [XLEN-1:0] ALU_ResultW,
   output logic [XLEN-1:0] ReadDataW,
   output logic [XLEN-1:0] PCPlus4W,
   output logic [4:0]      RdW,
   output logic            RegWriteEnW,
   output logic            MemtoRegW,
   output logic            JALW,
   output logic            MisalignW,
   output logic            BusErrW
);

   localparam int CW = $clog2(TIMEOUT + 2);

   typedef enum logic {IDLE, WAIT} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;

   logic access, aligned, memop, misop, timeout_hit, complete;

   function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] a);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{a, 3'b000} +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  load_fmt = {{24{b[7]}}, b};
         3'b100:  load_fmt = {24'b0, b};
         3'b001:  load_fmt = {{16{h[15]}}, h};
         3'b101:  load_fmt = {16'b0, h};
         default: load_fmt = w;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   store_be = 4'b0001 << a;
         2'b01:   store_be = a[1] ? 4'b1100 : 4'b0011;
         default: store_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   store_data = {4{d[7:0]}};
         2'b01:   store_data = {2{d[15:0]}};
         default: store_data = d;
      endcase
   endfunction

   // Unsupported size encodings (011, 110, 111) fall into the misaligned path.
   always_comb begin
      aligned = 1'b0;
      case (Funct3M)
         3'b000, 3'b100: aligned = 1'b1;
         3'b001, 3'b101: aligned = ~ALU_ResultM[0];
         3'b010:         aligned = (ALU_ResultM[1:0] == 2'b00);
         default:        aligned = 1'b0;
      endcase
   end

   assign access = ValidM & (MemReadM | MemWriteM);
   assign memop  = access & aligned;
   assign misop  = access & ~aligned;

   // cnt counts cycles the request has been outstanding, including the IDLE
   // cycle that raised it, so the abort lands on edge number TIMEOUT.
   assign timeout_hit = (TIMEOUT != 0) && (state == WAIT) && !dmem_ready &&
                        (cnt >= CW'(TIMEOUT - 1));
   assign complete    = dmem_ready & (((state == IDLE) & memop) | (state == WAIT));

   // Reset gates the bus and stall immediately, even with M inputs still live.
   assign dmem_req   = ~rst & (((state == IDLE) & memop) | (state == WAIT));
   assign StallM     = ~rst & (((state == IDLE) & memop & ~dmem_ready) |
                               ((state == WAIT) & ~dmem_ready & ~timeout_hit));
   assign dmem_we    = MemWriteM;
   assign dmem_addr  = {ALU_ResultM[XLEN-1:2], 2'b00};
   assign dmem_be    = MemWriteM ? store_be(Funct3M, ALU_ResultM[1:0]) : 4'b1111;
   assign dmem_wdata = store_data(Funct3M, WriteDataM);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (memop && !dmem_ready) begin
               state_nxt = WAIT;
               cnt_nxt   = CW'(1);
            end
         end
         WAIT: begin
            if (dmem_ready || timeout_hit) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (TIMEOUT != 0) begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // MEM/WB register: control fields default to a bubble; only a retiring,
   // non-stalled, non-faulting instruction writes its controls through.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ALU_ResultW <= '0;
         ReadDataW   <= '0;
         PCPlus4W    <= '0;
         RdW         <= '0;
         RegWriteEnW <= 1'b0;
         MemtoRegW   <= 1'b0;
         JALW        <= 1'b0;
         MisalignW   <= 1'b0;
         BusErrW     <= 1'b0;
      end else begin
         ALU_ResultW <= ALU_ResultM;
         PCPlus4W    <= PCPlus4M;
         RdW         <= RdM;
         RegWriteEnW <= 1'b0;
         MemtoRegW   <= 1'b0;
         JALW        <= 1'b0;
         MisalignW   <= 1'b0;
         BusErrW     <= 1'b0;
         if (complete && MemReadM && !MemWriteM)
            ReadDataW <= load_fmt(dmem_rdata, Funct3M, ALU_ResultM[1:0]);
         if (timeout_hit) begin
            BusErrW <= 1'b1;
         end else if (misop) begin
            MisalignW <= 1'b1;
         end else if (ValidM && !StallM) begin
            RegWriteEnW <= RegWriteEnM;
            MemtoRegW   <= MemtoRegM;
            JALW        <= JALM;
         end
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed-vector bench for memory_stage (TIMEOUT = 4).
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ValidM, MemReadM, MemWriteM, MemtoRegM, JALM, RegWriteEnM;
   logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;
   logic [2:0]  Funct3M;
   logic [4:0]  RdM;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        StallM;
   logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W;
   logic [4:0]  RdW;
   logic        RegWriteEnW, MemtoRegW, JALW, MisalignW, BusErrW;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   memory_stage #(.XLEN(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .ValidM(ValidM), .ALU_ResultM(ALU_ResultM),
      .WriteDataM(WriteDataM), .Funct3M(Funct3M), .MemReadM(MemReadM),
      .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .JALM(JALM),
      .RegWriteEnM(RegWriteEnM), .RdM(RdM), .PCPlus4M(PCPlus4M),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata), .StallM(StallM), .ALU_ResultW(ALU_ResultW),
      .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW),
      .RegWriteEnW(RegWriteEnW), .MemtoRegW(MemtoRegW), .JALW(JALW),
      .MisalignW(MisalignW), .BusErrW(BusErrW)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic bubble();
      ValidM = 0; MemReadM = 0; MemWriteM = 0; MemtoRegM = 0; JALM = 0;
      RegWriteEnM = 0; ALU_ResultM = 0; WriteDataM = 0; Funct3M = 0;
      RdM = 0; PCPlus4M = 0; dmem_ready = 0; dmem_rdata = 0;
   endtask

   // kind: 0 = ALU, 1 = load, 2 = store
   task automatic op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [4:0] rd);
      bubble();
      ValidM = 1; Funct3M = f3; ALU_ResultM = addr; WriteDataM = wd; RdM = rd;
      PCPlus4M = 32'h104;
      MemReadM = (kind == 1); MemWriteM = (kind == 2); MemtoRegM = (kind == 1);
      RegWriteEnM = (kind != 2);
   endtask

   // Advance to the next rising edge and settle past it.
   task automatic step();
      @(posedge clk); #1;
   endtask

   // Move to the falling edge, where inputs are changed.
   task automatic to_neg();
      @(negedge clk);
   endtask

   // Single-cycle load with ready in the same cycle.
   task automatic quick_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] exp);
      to_neg();
      op(1, f3, addr, 0, 5'd3);
      dmem_ready = 1; dmem_rdata = 32'h80112233;
      #1;
      chk({tag, "_stall"}, StallM, 0);
      chk({tag, "_req"}, dmem_req, 1);
      step();
      chk({tag, "_data"}, ReadDataW, exp);
      chk({tag, "_wen"}, RegWriteEnW, 1);
   endtask

   initial begin
      bubble();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", dmem_req, 0);
      chk("rst_stall", StallM, 0);
      chk("rst_wen", RegWriteEnW, 0);
      chk("rst_alu", ALU_ResultW, 0);
      to_neg();
      rst = 0;

      // ALU instruction passes through with one cycle of latency
      to_neg();
      op(0, 3'b000, 32'hAABBCCDD, 0, 5'd10);
      #1;
      chk("alu_req", dmem_req, 0);
      step();
      chk("alu_rd", RdW, 10);
      chk("alu_wen", RegWriteEnW, 1);
      chk("alu_res", ALU_ResultW, 32'hAABBCCDD);
      chk("alu_pc4", PCPlus4W, 32'h104);
      chk("alu_m2r", MemtoRegW, 0);

      to_neg();
      op(0, 3'b000, 32'h0, 0, 5'd1);
      JALM = 1;
      step();
      chk("jal_flag", JALW, 1);

      // Zero-wait-state loads of every size
      to_neg();
      op(1, 3'b000, 32'h1003, 0, 5'd3);
      dmem_ready = 1; dmem_rdata = 32'h80112233;
      #1;
      chk("lb_addr", dmem_addr, 32'h1000);
      chk("lb_be", dmem_be, 4'hF);
      chk("lb_we", dmem_we, 0);
      quick_load("lb", 3'b000, 32'h1003, 32'hFFFFFF80);
      chk("lb_m2r", MemtoRegW, 1);
      quick_load("lbu", 3'b100, 32'h1001, 32'h00000022);
      quick_load("lh", 3'b001, 32'h1002, 32'hFFFF8011);
      quick_load("lhu", 3'b101, 32'h1000, 32'h00002233);
      quick_load("lw", 3'b010, 32'h1000, 32'h80112233);

      // SH with three wait states
      to_neg();
      op(2, 3'b001, 32'h2002, 32'h0000BEEF, 5'd0);
      #1;
      chk("sh_be", dmem_be, 4'b1100);
      chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
      chk("sh_we", dmem_we, 1);
      chk("sh_addr", dmem_addr, 32'h2000);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("sh_stall%0d", i), StallM, 1);
         chk($sformatf("sh_req%0d", i), dmem_req, 1);
         step();
         chk($sformatf("sh_bub%0d", i), RegWriteEnW, 0);
         to_neg();
      end
      dmem_ready = 1;
      #1;
      chk("sh_done_stall", StallM, 0);
      chk("sh_done_req", dmem_req, 1);
      step();
      to_neg();
      bubble();
      #1;
      chk("sh_idle_req", dmem_req, 0);

      // Byte store lanes and full word store
      to_neg();
      op(2, 3'b000, 32'h3001, 32'h12345678, 5'd0);
      dmem_ready = 1;
      #1;
      chk("sb_be", dmem_be, 4'b0010);
      chk("sb_wdata", dmem_wdata, 32'h78787878);
      op(2, 3'b010, 32'h3004, 32'h12345678, 5'd0);
      dmem_ready = 1;
      #1;
      chk("sw_be", dmem_be, 4'hF);
      chk("sw_wdata", dmem_wdata, 32'h12345678);
      step();

      // Load with one wait state: bubble first, then the result
      to_neg();
      op(1, 3'b010, 32'h4000, 0, 5'd5);
      step();
      chk("lww_bub", RegWriteEnW, 0);
      to_neg();
      dmem_ready = 1; dmem_rdata = 32'hCAFEF00D;
      step();
      chk("lww_data", ReadDataW, 32'hCAFEF00D);
      chk("lww_wen", RegWriteEnW, 1);
      chk("lww_rd", RdW, 5);

      // Misaligned word and unsupported size
      to_neg();
      op(1, 3'b010, 32'h0006, 0, 5'd7);
      #1;
      chk("mis_req", dmem_req, 0);
      chk("mis_stall", StallM, 0);
      step();
      chk("mis_flag", MisalignW, 1);
      chk("mis_wen", RegWriteEnW, 0);
      to_neg();
      op(1, 3'b011, 32'h0008, 0, 5'd7);
      #1;
      chk("unsup_req", dmem_req, 0);
      step();
      chk("unsup_flag", MisalignW, 1);
      to_neg();
      bubble();
      step();
      chk("mis_clear", MisalignW, 0);

      // Timeout abort with TIMEOUT = 4
      to_neg();
      op(1, 3'b010, 32'h0010, 0, 5'd9);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("to_stall%0d", i), StallM, 1);
         step();
         chk($sformatf("to_noerr%0d", i), BusErrW, 0);
         to_neg();
      end
      #1;
      chk("to_stall3", StallM, 0);
      step();
      chk("to_buserr", BusErrW, 1);
      chk("to_wen", RegWriteEnW, 0);
      to_neg();
      bubble();
      #1;
      chk("to_req_low", dmem_req, 0);
      step();
      chk("to_err_clear", BusErrW, 0);

      // Reset while waiting
      to_neg();
      op(1, 3'b010, 32'h0020, 0, 5'd4);
      step();
      step();
      to_neg();
      rst = 1;
      #1;
      chk("rstw_req", dmem_req, 0);
      chk("rstw_stall", StallM, 0);
      chk("rstw_alu", ALU_ResultW, 0);
      chk("rstw_rd", RdW, 0);
      chk("rstw_pc4", PCPlus4W, 0);
      to_neg();
      bubble();
      rst = 0;
      step();
      chk("rstw_buserr", BusErrW, 0);
      chk("rstw_wen", RegWriteEnW, 0);
      to_neg();
      #1;
      chk("rstw_idle_req", dmem_req, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
